// File: rtl/usb_pkg.sv
// Shared USB definitions: IN endpoint state encoding and full-speed packet size.
package usb_pkg;

  // Largest bulk payload on a full-speed link.
  localparam int USB_FS_MAX_PACKET = 64;

  // IN endpoint packetiser states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_ACK = 2'd3
  } in_ep_state_t;

endpackage

// File: rtl/usb_uart_in_ep.sv
// Bulk IN endpoint: packs the outgoing UART byte stream into USB IN packets
// in the protocol engine buffer. A packet closes when full or after the stream
// has been idle; a zero-length packet terminates a transfer that ended on a
// full packet once the stream stays quiet.
module usb_uart_in_ep
  import usb_pkg::*;
#(
  parameter int MAX_PACKET   = USB_FS_MAX_PACKET,
  parameter int FLUSH_CYCLES = 48000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] uart_in_data,
  input  logic       uart_in_valid,
  output logic       uart_in_ready,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked
);

  localparam int CW = $clog2(MAX_PACKET + 1);
  localparam int TW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_PACKET);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT  = TW'(FLUSH_CYCLES);

  in_ep_state_t  state_reg;
  logic [CW-1:0] count_reg;
  logic [TW-1:0] idle_timer_reg;
  logic [TW-1:0] zlp_timer_reg;
  logic          zlp_pending_reg;
  logic          full_sent_reg;
  logic          req_reg;
  logic          done_reg;

  logic          put;
  logic [CW-1:0] count_next;

  // Bytes flow straight from the stream into the PE buffer; nothing is
  // accepted while a ZLP is queued so that it goes out with an empty buffer.
  assign uart_in_ready = (state_reg == ST_FILL) && in_ep_grant && in_ep_data_free &&
                         (count_reg < COUNT_MAX) && !zlp_pending_reg;
  assign put             = uart_in_valid && uart_in_ready;
  assign in_ep_data_put  = put;
  assign in_ep_data      = put ? uart_in_data : 8'd0;
  assign in_ep_req       = req_reg;
  assign in_ep_data_done = done_reg;
  assign in_ep_stall     = 1'b0;
  assign count_next      = count_reg + 1'b1;

  // Packetiser FSM with its byte count, idle/ZLP timers and registered outputs.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      count_reg       <= '0;
      idle_timer_reg  <= '0;
      zlp_timer_reg   <= '0;
      zlp_pending_reg <= 1'b0;
      full_sent_reg   <= 1'b0;
      req_reg         <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (uart_in_valid) begin
            // New data after a full packet: the transfer continues, no ZLP.
            full_sent_reg <= 1'b0;
            zlp_timer_reg <= '0;
          end else if (full_sent_reg) begin
            if (zlp_timer_reg == FLUSH_LAST) begin
              zlp_pending_reg <= 1'b1;
            end
            if (zlp_timer_reg != TIMER_SAT) begin
              zlp_timer_reg <= zlp_timer_reg + 1'b1;
            end
          end
          if (uart_in_valid || zlp_pending_reg) begin
            state_reg <= ST_FILL;
            req_reg   <= 1'b1;
          end
        end

        ST_FILL: begin
          if (put) begin
            count_reg      <= count_next;
            idle_timer_reg <= '0;
          end else if ((count_reg != '0) && (idle_timer_reg != TIMER_SAT)) begin
            idle_timer_reg <= idle_timer_reg + 1'b1;
          end
          if ((put && (count_next == COUNT_MAX)) ||
              (!put && (count_reg != '0) && (idle_timer_reg == FLUSH_LAST)) ||
              (zlp_pending_reg && in_ep_grant)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end

        ST_DONE: begin
          full_sent_reg   <= (count_reg == COUNT_MAX);
          zlp_pending_reg <= 1'b0;
          state_reg       <= ST_WAIT_ACK;
          req_reg         <= 1'b0;
          done_reg        <= 1'b0;
        end

        ST_WAIT_ACK: begin
          if (in_ep_acked) begin
            count_reg      <= '0;
            idle_timer_reg <= '0;
            zlp_timer_reg  <= '0;
            state_reg      <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          req_reg   <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_uart_in_ep.sv
// Self-checking bench for usb_uart_in_ep: directed scenarios plus randomized
// bursts, checked against a packet-level model (byte order, packet lengths,
// close latencies, ZLP rule).
module tb_usb_uart_in_ep;

  localparam int MAX   = 64;
  localparam int FLUSH = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked;

  usb_uart_in_ep #(.MAX_PACKET(MAX), .FLUSH_CYCLES(FLUSH)) dut (
    .clk_48mhz      (clk),
    .reset          (reset),
    .uart_in_data   (uart_in_data),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ready  (uart_in_ready),
    .in_ep_req      (in_ep_req),
    .in_ep_grant    (in_ep_grant),
    .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put (in_ep_data_put),
    .in_ep_data     (in_ep_data),
    .in_ep_data_done(in_ep_data_done),
    .in_ep_stall    (in_ep_stall),
    .in_ep_acked    (in_ep_acked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state: bytes offered in order, packets seen, put times.
  logic [7:0] exp_q[$];
  int         pkt_q[$];
  int         put_cyc_q[$];
  int         pkt_len   = 0;
  int         last_put  = 0;
  int         ack_cyc   = 0;
  bit         waiting   = 0;
  bit         last_full = 0;

  // Packet-level monitor.
  always @(negedge clk) begin
    if (reset) begin
      pkt_len   = 0;
      waiting   = 0;
      last_full = 0;
    end else begin
      check_val("stall_zero", in_ep_stall, 0);
      if (!uart_in_valid) check_val("data_idle_zero", in_ep_data, 0);
      if (in_ep_data_put) begin
        check_val("put_handshake", uart_in_ready & uart_in_valid, 1);
        check_val("put_in_wait", waiting, 0);
        check_val("pkt_overflow", pkt_len < MAX, 1);
        if (exp_q.size() == 0) check_val("put_unexpected", exp_q.size(), 1);
        else check_val("put_data", in_ep_data, exp_q.pop_front());
        pkt_len++;
        last_put  = cyc;
        last_full = 0;
        put_cyc_q.push_back(cyc);
      end
      if (in_ep_data_done) begin
        if (pkt_len == MAX) check_val("done_full_lat", cyc - last_put, 1);
        else if (pkt_len > 0) check_val("done_flush_lat", cyc - last_put, FLUSH + 1);
        else begin
          check_val("zlp_after_full", last_full, 1);
          check_val("zlp_lat_ok", (cyc - ack_cyc >= FLUSH + 1) && (cyc - ack_cyc <= FLUSH + 3), 1);
        end
        $display("packet: len=%0d done_cycle=%0d", pkt_len, cyc);
        pkt_q.push_back(pkt_len);
        last_full = (pkt_len == MAX);
        pkt_len   = 0;
        waiting   = 1;
      end else if (waiting) begin
        check_val("ready_in_wait", uart_in_ready, 0);
        check_val("req_in_wait", in_ep_req, 0);
        if (in_ep_acked) begin
          waiting = 0;
          ack_cyc = cyc;
        end
      end
    end
  end

  // Host: ACKs each packet ack_delay cycles after done; optional stray ACKs
  // while no packet is outstanding.
  int ack_delay = 2;
  bit stray_en  = 0;
  int ack_cd    = 0;
  bit stray_now;
  initial begin
    in_ep_acked = 1'b0;
    forever begin
      @(negedge clk);
      stray_now = 0;
      if (reset) ack_cd = 0;
      else if (in_ep_data_done) ack_cd = ack_delay;
      else if (ack_cd == 0 && !waiting && stray_en && $urandom_range(0, 7) == 0) stray_now = 1;
      @(posedge clk);
      #1;
      in_ep_acked = 1'b0;
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) in_ep_acked = 1'b1;
      end else if (stray_now) begin
        in_ep_acked = 1'b1;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int guard;
    uart_in_data  = b;
    uart_in_valid = 1'b1;
    exp_q.push_back(b);
    guard = 0;
    @(negedge clk);
    while (!uart_in_ready && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 500) begin
      check_val("accept_timeout", guard, 0);
      void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
    uart_in_valid = 1'b0;
  endtask

  task automatic wait_pkt(input string tag, input int exp_len);
    int guard;
    guard = 0;
    while (pkt_q.size() == 0 && guard < 4 * FLUSH + 500) begin
      guard++;
      @(posedge clk);
    end
    #1;
    if (pkt_q.size() == 0) check_val({tag, "_timeout"}, pkt_q.size(), 1);
    else check_val(tag, pkt_q.pop_front(), exp_len);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int v, t0, n, rem;

  initial begin
    reset = 1'b1;
    uart_in_data = 8'd0;
    uart_in_valid = 1'b0;
    in_ep_grant = 1'b1;
    in_ep_data_free = 1'b1;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    check_val("rst_req", in_ep_req, 0);
    check_val("rst_ready", uart_in_ready, 0);
    check_val("rst_put", in_ep_data_put, 0);
    check_val("rst_done", in_ep_data_done, 0);
    check_val("rst_data", in_ep_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(3);

    // Partial packet: 3 consecutive puts, flush close, back to idle after ACK.
    put_cyc_q.delete();
    v = cyc;
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    wait_pkt("partial_len", 3);
    check_val("partial_puts", put_cyc_q.size(), 3);
    if (put_cyc_q.size() == 3) begin
      check_val("first_put_lat", put_cyc_q[0] - v, 1);
      check_val("puts_consecutive", (put_cyc_q[1] - put_cyc_q[0] == 1) && (put_cyc_q[2] - put_cyc_q[1] == 1), 1);
    end
    idle(ack_delay + 2);
    @(negedge clk);
    check_val("idle_after_ack_req", in_ep_req, 0);
    check_val("idle_after_ack_ack_seen", waiting, 0);
    @(posedge clk);
    #1;

    // Full packet back-to-back, then ZLP after idle.
    put_cyc_q.delete();
    for (int i = 0; i < MAX; i++) push_byte(8'($urandom));
    check_val("full_puts_consecutive", put_cyc_q[MAX-1] - put_cyc_q[0], MAX - 1);
    wait_pkt("full_len", MAX);
    wait_pkt("zlp_len", 0);
    idle(ack_delay + 4);

    // Full packet with the 65th byte held until ACK.
    ack_delay = 30;
    for (int i = 0; i < MAX; i++) push_byte(8'($urandom));
    t0 = cyc;
    push_byte(8'hA5);
    check_val("byte65_held", (cyc - t0) > 30, 1);
    wait_pkt("hold_full_len", MAX);
    wait_pkt("hold_next_len", 1);
    ack_delay = 2;
    idle(ack_delay + 4);

    // Full packet, then one byte soon after: no ZLP, a 1-byte packet instead.
    for (int i = 0; i < MAX; i++) push_byte(8'($urandom));
    wait_pkt("nozlp_full_len", MAX);
    idle(20);
    push_byte(8'h5A);
    wait_pkt("nozlp_one_len", 1);
    idle(2 * FLUSH + 20);
    check_val("no_zlp", pkt_q.size(), 0);

    // Backpressure: buffer full for 20 cycles after 10 bytes.
    for (int i = 0; i < 10; i++) push_byte(8'(i + 1));
    in_ep_data_free = 1'b0;
    uart_in_data = 8'd11;
    uart_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("bp_ready", uart_in_ready, 0);
      check_val("bp_put", in_ep_data_put, 0);
    end
    @(posedge clk);
    #1;
    uart_in_valid = 1'b0;
    in_ep_data_free = 1'b1;
    for (int i = 10; i < 30; i++) push_byte(8'(i + 1));
    wait_pkt("bp_len", 30);
    idle(ack_delay + 4);

    // Grant loss mid-fill: request held, count preserved.
    for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i));
    in_ep_grant = 1'b0;
    uart_in_data = 8'h88;
    uart_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("gl_req", in_ep_req, 1);
      check_val("gl_ready", uart_in_ready, 0);
    end
    @(posedge clk);
    #1;
    uart_in_valid = 1'b0;
    in_ep_grant = 1'b1;
    for (int i = 8; i < 16; i++) push_byte(8'(8'h80 + i));
    wait_pkt("gl_len", 16);
    idle(ack_delay + 4);

    // Reset after 5 puts: outputs clear, fresh packet starts at count 0.
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("mr_req", in_ep_req, 0);
    check_val("mr_ready", uart_in_ready, 0);
    check_val("mr_put", in_ep_data_put, 0);
    check_val("mr_done", in_ep_data_done, 0);
    check_val("mr_data", in_ep_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    push_byte(8'hD0);
    push_byte(8'hD1);
    wait_pkt("mr_fresh_len", 2);
    idle(ack_delay + 4);

    // Randomized bursts with gaps, short backpressure and stray ACKs.
    stray_en = 1;
    for (int b = 0; b < 6; b++) begin
      ack_delay = $urandom_range(1, 6);
      n = (b == 2) ? MAX * 2 : $urandom_range(1, 150);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          in_ep_data_free = 1'b0;
          idle($urandom_range(1, 3));
          in_ep_data_free = 1'b1;
        end
        idle($urandom_range(0, 3));
        push_byte(8'($urandom));
      end
      for (int k = 0; k < n / MAX; k++) wait_pkt("rand_full_len", MAX);
      rem = n % MAX;
      wait_pkt("rand_tail_len", rem);
      idle(ack_delay + 4);
    end
    stray_en = 0;
    idle(2 * FLUSH + 20);
    check_val("final_no_extra_pkts", pkt_q.size(), 0);
    check_val("final_bytes_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
